gsim: RTL and testbench

- Fixed-point Gauss-Seidel solver for a fixed 16x16 symmetric banded system A·x = b.
- Row i of A: diagonal 20, offsets ±1 coefficient -13, offsets ±2 coefficient +6, offsets ±3 coefficient -1. Terms outside the 0..15 range are absent.
- Accepts 16 signed-integer b values as a stream, iterates internally, then streams the 16 solutions out in Q16.16 format.
- Standalone compute block between an input producer and a result consumer.

---
 rtl/gsim_if.sv | 11 +
 rtl/gsim.sv | 132 +++++++++++++
 tb/tb_gsim.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/gsim_if.sv
// Stream bundle between the b producer, the solver and the result consumer.
// The producer side drives in_en/b_in; the solver drives out_valid/x_out.
interface gsim_if;
  logic               in_en;
  logic signed [15:0] b_in;
  logic               out_valid;
  logic signed [31:0] x_out;

  modport master (output in_en, b_in, input out_valid, x_out);
  modport slave  (input in_en, b_in, output out_valid, x_out);
endinterface

// File: rtl/gsim.sv
// Fixed-point Gauss-Seidel solver for the 16x16 banded system; 16*ITER+1 cycles from last b to first x.
// No backpressure: in_en outside IDLE is dropped and the 16 results stream out unconditionally.
module gsim #(
  parameter int N    = 16,
  parameter int ITER = 512,
  parameter int FRAC = 16
) (
  input  logic  clk,
  input  logic  reset,
  gsim_if.slave io
);
  localparam int SW = $clog2(ITER + 1);
  localparam int AW = 41;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
  state_t state, state_nxt;

  logic signed [15:0] b_reg [N];
  logic signed [31:0] x_reg [N];
  logic [3:0]         cnt;
  logic [3:0]         idx;
  logic [SW-1:0]      sweep;
  logic               last_row;
  logic               last_sweep;

  function automatic logic signed [AW-1:0] sx(input logic signed [31:0] v);
    return {{(AW-32){v[31]}}, v};
  endfunction

  assign last_row   = (idx == 4'(N - 1));
  assign last_sweep = (sweep == SW'(ITER - 1));

  // Neighbours of the row being updated; rows before idx already hold this sweep's values.
  logic signed [31:0] xm1, xm2, xm3, xp1, xp2, xp3;
  always_comb begin
    xm1 = '0;
    xm2 = '0;
    xm3 = '0;
    xp1 = '0;
    xp2 = '0;
    xp3 = '0;
    if (idx >= 4'd1)  xm1 = x_reg[idx - 4'd1];
    if (idx >= 4'd2)  xm2 = x_reg[idx - 4'd2];
    if (idx >= 4'd3)  xm3 = x_reg[idx - 4'd3];
    if (idx <= 4'd14) xp1 = x_reg[idx + 4'd1];
    if (idx <= 4'd13) xp2 = x_reg[idx + 4'd2];
    if (idx <= 4'd12) xp3 = x_reg[idx + 4'd3];
  end

  logic signed [AW-1:0] b_fix;
  logic signed [AW-1:0] acc;
  logic        [AW-1:0] acc_mag;
  logic        [AW-1:0] q_mag;
  logic signed [AW-1:0] q;
  logic signed [31:0]   x_new;

  // Exact divide by 20 on the magnitude gives round-half-away-from-zero.
  always_comb begin
    b_fix   = {{(AW-16){b_reg[idx][15]}}, b_reg[idx]} <<< FRAC;
    acc     = b_fix
            + 41'sd13 * (sx(xm1) + sx(xp1))
            - 41'sd6  * (sx(xm2) + sx(xp2))
            + sx(xm3) + sx(xp3);
    acc_mag = acc[AW-1] ? -acc : acc;
    q_mag   = (acc_mag + 41'd10) / 41'd20;
    q       = acc[AW-1] ? -$signed(q_mag) : $signed(q_mag);
    if (q > 41'sd2147483647)
      x_new = 32'sh7FFF_FFFF;
    else if (q < -41'sd2147483648)
      x_new = 32'sh8000_0000;
    else
      x_new = q[31:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.in_en && cnt == 4'(N - 1)) state_nxt = CALC;
      CALC:    if (last_row && last_sweep)       state_nxt = OUT;
      OUT:     if (last_row)                     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      idx          <= '0;
      sweep        <= '0;
      io.out_valid <= 1'b0;
      io.x_out     <= '0;
      for (int i = 0; i < N; i++) begin
        b_reg[i] <= '0;
        x_reg[i] <= '0;
      end
    end else begin
      io.out_valid <= 1'b0;
      io.x_out     <= '0;
      case (state)
        IDLE: begin
          if (io.in_en) begin
            b_reg[cnt] <= io.b_in;
            cnt        <= cnt + 4'd1;
            if (cnt == 4'(N - 1)) begin
              for (int i = 0; i < N; i++) x_reg[i] <= '0;
              idx   <= '0;
              sweep <= '0;
            end
          end
        end
        CALC: begin
          x_reg[idx] <= x_new;
          idx        <= idx + 4'd1;
          if (last_row) sweep <= sweep + SW'(1);
        end
        OUT: begin
          io.out_valid <= 1'b1;
          io.x_out     <= x_reg[idx];
          idx          <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gsim.sv
// Bench for gsim: a plain integer Gauss-Seidel model fills an expectation queue that a
// negedge compare process drains; directed batches add hand-computed literal checks.
module tb_gsim;
  localparam int ITER = 512;

  logic clk;
  logic reset;
  gsim_if bus();

  gsim dut (.clk(clk), .reset(reset), .io(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic signed [31:0] exp_q[$];
  logic signed [31:0] got_q[$];
  logic signed [15:0] cur [16];

  int gold_i [16] = '{20020, 5028, -20780, -17044, 25330, -30888, -662, -21762,
                      31370, 13939, 31, -1895, -28860, 11926, -29987, -28085};

  function automatic longint a_coef(int i, int j);
    int d;
    d = (i > j) ? i - j : j - i;
    case (d)
      0:       return 20;
      1:       return -13;
      2:       return 6;
      3:       return -1;
      default: return 0;
    endcase
  endfunction

  // Solve A.x = b by ITER sweeps straight from the matrix entries, in Q16.16 integers.
  task automatic model(input logic signed [15:0] bv [16]);
    longint x [16];
    longint s, q;
    for (int i = 0; i < 16; i++) x[i] = 0;
    for (int k = 0; k < ITER; k++) begin
      for (int i = 0; i < 16; i++) begin
        s = longint'(bv[i]) * 65536;
        for (int j = 0; j < 16; j++)
          if (j != i) s -= a_coef(i, j) * x[j];
        q = (s >= 0) ? (s + 10) / 20 : -((-s + 10) / 20);
        if (q > 64'sd2147483647)  q = 64'sd2147483647;
        if (q < -64'sd2147483648) q = -64'sd2147483648;
        x[i] = q;
      end
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(x[i]));
  endtask

  function automatic real residual();
    real r, t;
    r = 0.0;
    for (int i = 0; i < 16; i++) begin
      t = -real'(cur[i]);
      for (int j = 0; j < 16; j++)
        t += real'(a_coef(i, j)) * real'(got_q[j]) / 65536.0;
      r += t * t;
    end
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp, input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    nvec++;
    if (d > tol) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic check_below(input string name, input real act, input real limit);
    nvec++;
    if (!(act < limit)) begin
      nerr++;
      $display("FAIL %s: got %g, required below %g", name, act, limit);
    end
  endtask

  always @(negedge clk) begin
    logic signed [31:0] e;
    if (reset && bus.out_valid) begin
      got_q.push_back(bus.x_out);
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL spurious_out_valid: x_out=%0d, no result expected", bus.x_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.x_out !== e) begin
          nerr++;
          $display("FAIL model_x_out: got %0d, expected %0d", bus.x_out, e);
        end
      end
    end
  end

  task automatic send(input bit gapped);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.in_en = 1'b1;
      bus.b_in  = cur[i];
      if (gapped) begin
        @(negedge clk);
        bus.in_en = 1'b0;
        bus.b_in  = 16'(i * 77);
      end
    end
  endtask

  // Junk in_en during the first CALC cycles must be dropped.
  task automatic run_batch(input string name, input bit gapped, output int first_lat);
    int lat;
    got_q.delete();
    model(cur);
    send(gapped);
    lat = 0;
    first_lat = 0;
    while (got_q.size() < 16 && lat < 16 * ITER + 200) begin
      @(negedge clk);
      lat++;
      if (lat < 20) begin
        bus.in_en = 1'b1;
        bus.b_in  = 16'($urandom);
      end else begin
        bus.in_en = 1'b0;
      end
      if (first_lat == 0 && got_q.size() > 0) first_lat = lat;
    end
    repeat (5) @(negedge clk);
    check({name, "_count"}, got_q.size(), 16, 0);
    check({name, "_drained"}, exp_q.size(), 0, 0);
    exp_q.delete();
  endtask

  task automatic load_gold();
    for (int i = 0; i < 16; i++) cur[i] = 16'(gold_i[i]);
  endtask

  initial begin
    #2_000_000;
    nerr++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1);
  end

  initial begin
    int lat1, lat2, lat_tmp;
    real bb;
    reset     = 1'b0;
    bus.in_en = 1'b0;
    bus.b_in  = '0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0, 0);
    check("reset_x_out", bus.x_out, 0, 0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      repeat (10) @(negedge clk);
      check("idle_out_valid", bus.out_valid, 0, 0);
      check("idle_x_out", bus.x_out, 0, 0);
    end

    for (int i = 0; i < 16; i++) cur[i] = '0;
    run_batch("zero", 1'b0, lat_tmp);
    check("zero_x0", got_q[0], 0, 0);
    check("zero_x15", got_q[15], 0, 0);

    load_gold();
    run_batch("golden", 1'b0, lat1);
    check("golden_x0", got_q[0], 123525219, 64);
    check("golden_x2", got_q[2], -192415276, 64);
    check("golden_x8", got_q[8], 317464482, 64);
    check("golden_x15", got_q[15], -260223057, 64);
    check_below("golden_residual", residual(), 0.3);
    nvec++;
    if (lat1 < 16 * ITER) begin
      nerr++;
      $display("FAIL latency_min: got %0d cycles, required at least %0d", lat1, 16 * ITER);
    end

    for (int i = 0; i < 16; i++) cur[i] = (i % 2 == 0) ? 16'sh7FFF : 16'sh8000;
    run_batch("extreme", 1'b0, lat_tmp);
    bb = 0.0;
    for (int i = 0; i < 16; i++) bb += real'(cur[i]) * real'(cur[i]);
    check_below("extreme_rel_residual", residual() / bb, 1e-6);

    load_gold();
    run_batch("gapped", 1'b1, lat_tmp);
    check("gapped_x0", got_q[0], 123525219, 64);
    check("gapped_x15", got_q[15], -260223057, 64);

    // Abort mid-CALC: nothing may come out, with or without the pending batch.
    got_q.delete();
    load_gold();
    send(1'b0);
    @(negedge clk);
    bus.in_en = 1'b0;
    repeat (8 * ITER) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_out_valid", bus.out_valid, 0, 0);
    reset = 1'b1;
    repeat (16 * ITER + 100) @(negedge clk);
    check("abort_no_output", got_q.size(), 0, 0);

    load_gold();
    run_batch("golden2", 1'b0, lat2);
    check("golden2_x0", got_q[0], 123525219, 64);
    check("latency_repeat", lat2, lat1, 0);

    for (int i = 0; i < 16; i++) cur[i] = '0;
    cur[0] = 16'sd20;
    cur[1] = -16'sd13;
    cur[2] = 16'sd6;
    cur[3] = -16'sd1;
    run_batch("unit", 1'b0, lat_tmp);
    check("unit_x0", got_q[0], 65536, 16);
    check("unit_x1", got_q[1], 0, 16);
    check("unit_x9", got_q[9], 0, 16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
